// File: rtl/fb_rx_pkg.sv
// Shared types and default sizes for the framebuffer link receiver.
package fb_rx_pkg;

  localparam int FB_DATA_W          = 30;
  localparam int FB_WORDS_PER_SLICE = 512;

  typedef enum logic [1:0] {
    ALIGN,
    BLANK,
    CAPTURE,
    DROP
  } fb_rx_state_t;

endpackage

// File: rtl/fb_rx_bank_ram.sv
// Ping-pong slice store: one write port, one registered read port.
// The address MSB selects the bank. Contents are not reset.
module fb_rx_bank_ram
  import fb_rx_pkg::*;
#(
  parameter int DATA_W = FB_DATA_W,
  parameter int ADDR_W = $clog2(FB_WORDS_PER_SLICE) + 1
) (
  input  logic              clk_33,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_33) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/framebuffer_receiver.sv
// Captures framebuffer link slices into a ping-pong store and exposes the last full slice.
// Optional error counters are enabled by defining FB_RX_ERR_CNT_EN.
module framebuffer_receiver
  import fb_rx_pkg::*;
#(
  parameter int WORDS_PER_SLICE = FB_WORDS_PER_SLICE,
  parameter int DATA_W          = FB_DATA_W,
  parameter int MIN_BLANK       = 8
) (
  input  logic                               clk_33,
  input  logic                               nrst,
  input  logic [DATA_W-1:0]                  data,
  input  logic                               sync,
  input  logic [$clog2(WORDS_PER_SLICE)-1:0] rd_addr,
  output logic [DATA_W-1:0]                  rd_data,
  output logic                               slice_ready,
  output logic                               frame_valid,
  output logic                               err_short,
  output logic                               err_long
`ifdef FB_RX_ERR_CNT_EN
  ,
  output logic [15:0]                        short_cnt,
  output logic [15:0]                        long_cnt
`endif
);

  localparam int AW = $clog2(WORDS_PER_SLICE);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MIN_BLANK + 1);
  localparam logic [CW-1:0] FULL      = CW'(WORDS_PER_SLICE);
  localparam logic [BW-1:0] BLANK_MIN = BW'(MIN_BLANK);
  localparam logic [BW-1:0] BLANK_SAT = '1;

  logic [DATA_W-1:0] data_q;
  logic              sync_q;
  fb_rx_state_t      state;
  logic [BW-1:0]     blank_cnt;
  logic [CW-1:0]     word_cnt;
  logic              wr_bank;
  logic              rd_bank;
  logic              we;
  logic [AW:0]       waddr;
  logic [DATA_W-1:0] ram_q;
  logic              in_range_q;

  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      data_q <= '0;
      sync_q <= 1'b0;
    end else begin
      data_q <= data;
      sync_q <= sync;
    end
  end

  // word_cnt is 0 on every entry to BLANK, so the first word lands at index 0
  always_comb begin
    we    = 1'b0;
    waddr = {wr_bank, word_cnt[AW-1:0]};
    case (state)
      BLANK:   we = !sync_q && (blank_cnt >= BLANK_MIN);
      CAPTURE: we = !sync_q && (word_cnt != FULL);
      default: we = 1'b0;
    endcase
  end

  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      state       <= ALIGN;
      blank_cnt   <= '0;
      word_cnt    <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      slice_ready <= 1'b0;
      frame_valid <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else begin
      slice_ready <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      case (state)
        ALIGN: begin
          if (sync_q) begin
            state     <= BLANK;
            blank_cnt <= '0;
          end
        end
        BLANK: begin
          if (sync_q) begin
            if (blank_cnt != BLANK_SAT) blank_cnt <= blank_cnt + 1'b1;
          end else if (blank_cnt >= BLANK_MIN) begin
            state    <= CAPTURE;
            word_cnt <= CW'(1);
          end else begin
            state <= DROP;
          end
        end
        CAPTURE: begin
          if (sync_q) begin
            state     <= BLANK;
            blank_cnt <= '0;
            word_cnt  <= '0;
            if (word_cnt == FULL) begin
              wr_bank     <= ~wr_bank;
              rd_bank     <= ~rd_bank;
              slice_ready <= 1'b1;
              frame_valid <= 1'b1;
            end else begin
              err_short <= 1'b1;
            end
          end else if (word_cnt == FULL) begin
            state    <= DROP;
            err_long <= 1'b1;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end
        DROP: begin
          if (sync_q) begin
            state     <= BLANK;
            blank_cnt <= '0;
            word_cnt  <= '0;
          end
        end
        default: state <= ALIGN;
      endcase
    end
  end

  fb_rx_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (AW + 1)
  ) u_ram (
    .clk_33 (clk_33),
    .we     (we),
    .waddr  (waddr),
    .wdata  (data_q),
    .raddr  ({rd_bank, rd_addr}),
    .rdata  (ram_q)
  );

  // Out-of-range reads return zero; the flag follows the RAM's one-cycle latency
  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) in_range_q <= 1'b0;
    else       in_range_q <= ({1'b0, rd_addr} < FULL);
  end

  assign rd_data = in_range_q ? ram_q : '0;

`ifdef FB_RX_ERR_CNT_EN
  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      short_cnt <= '0;
      long_cnt  <= '0;
    end else begin
      if (err_short && short_cnt != 16'hFFFF) short_cnt <= short_cnt + 16'd1;
      if (err_long && long_cnt != 16'hFFFF)   long_cnt  <= long_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_framebuffer_receiver.sv
// Scoreboard bench for framebuffer_receiver: expected pulses and read words are
// queued as stimulus is driven and retired as the receiver produces them.
`timescale 1ns/1ps
module tb_framebuffer_receiver;
  import fb_rx_pkg::*;

  localparam int WPS = FB_WORDS_PER_SLICE;
  localparam int DW  = FB_DATA_W;
  localparam int AW  = $clog2(WPS);
  localparam logic [2:0] EV_READY = 3'b100;
  localparam logic [2:0] EV_SHORT = 3'b010;
  localparam logic [2:0] EV_LONG  = 3'b001;

  logic          clk_33 = 1'b0;
  logic          nrst;
  logic [DW-1:0] data;
  logic          sync;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          slice_ready;
  logic          frame_valid;
  logic          err_short;
  logic          err_long;
`ifdef FB_RX_ERR_CNT_EN
  logic [15:0]   short_cnt;
  logic [15:0]   long_cnt;
`endif

  int            n_total = 0;
  int            n_bad   = 0;
  logic [2:0]    ev_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] golden[WPS];

  always #15 clk_33 = ~clk_33;

  framebuffer_receiver dut (
    .clk_33      (clk_33),
    .nrst        (nrst),
    .data        (data),
    .sync        (sync),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .slice_ready (slice_ready),
    .frame_valid (frame_valid),
    .err_short   (err_short),
    .err_long    (err_long)
`ifdef FB_RX_ERR_CNT_EN
    ,
    .short_cnt   (short_cnt),
    .long_cnt    (long_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic s);
    @(posedge clk_33);
    #1;
    data = d;
    sync = s;
  endtask

  task automatic sendBlank(input int n);
    repeat (n) applyStimulus('0, 1'b1);
  endtask

  task automatic sendWords(input int n, input int base, input bit captured);
    for (int i = 0; i < n; i++) begin
      if (captured && i == WPS) ev_q.push_back(EV_LONG);
      applyStimulus(DW'(base + i), 1'b0);
    end
  endtask

  // Sync-low run followed by a long blank; a captured full slice becomes the new golden copy
  task automatic sendSlice(input int n, input int base, input bit captured);
    sendWords(n, base, captured);
    if (captured && n == WPS) ev_q.push_back(EV_READY);
    if (captured && n < WPS)  ev_q.push_back(EV_SHORT);
    sendBlank(72);
    if (captured && n == WPS)
      for (int i = 0; i < WPS; i++) golden[i] = DW'(base + i);
    checkOutput("pending_events", ev_q.size(), 0);
  endtask

  task automatic readCheck(input string tag, input int addr, input logic [DW-1:0] expected);
    @(posedge clk_33);
    #1;
    rd_addr = AW'(addr);
    rd_q.push_back(expected);
    @(posedge clk_33);
    @(negedge clk_33);
    checkOutput(tag, rd_data, rd_q.pop_front());
  endtask

  task automatic readAll(input string tag);
    for (int i = 0; i < WPS; i++) readCheck(tag, i, golden[i]);
  endtask

  task automatic readSpot(input string tag);
    readCheck(tag, 0, golden[0]);
    readCheck(tag, 150, golden[150]);
    readCheck(tag, 299, golden[299]);
    readCheck(tag, WPS - 1, golden[WPS-1]);
  endtask

  always @(negedge clk_33) begin
    if (nrst === 1'b1 && (slice_ready || err_short || err_long)) begin
      if (ev_q.size() == 0)
        checkOutput("unexpected_event", {29'd0, slice_ready, err_short, err_long}, 0);
      else
        checkOutput("event", {29'd0, slice_ready, err_short, err_long}, {29'd0, ev_q.pop_front()});
    end
  end

  initial begin
    #10_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    nrst    = 1'b0;
    data    = '0;
    sync    = 1'b1;
    rd_addr = '0;
    repeat (3) @(posedge clk_33);
    @(negedge clk_33);
    checkOutput("rst_slice_ready", slice_ready, 0);
    checkOutput("rst_frame_valid", frame_valid, 0);
    checkOutput("rst_err_short", err_short, 0);
    checkOutput("rst_err_long", err_long, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    nrst = 1'b1;

    $display("[TB] full slice then blank");
    sendBlank(72);
    sendSlice(WPS, 0, 1'b1);
    checkOutput("t1_frame_valid", frame_valid, 1);
    readAll("t1_read");

    $display("[TB] short slice");
    sendSlice(300, 1000, 1'b1);
    readSpot("t2_read_old");

    $display("[TB] long slice, short blank, then good slice");
    sendWords(520, 5000, 1'b1);
    sendBlank(4);
    sendWords(WPS, 7000, 1'b0);
    sendBlank(72);
    checkOutput("t34_pending", ev_q.size(), 0);
    readSpot("t34_read_old");
    sendSlice(WPS, 20000, 1'b1);
    readSpot("t34_read_new");

    $display("[TB] reset mid-slice");
    sendWords(200, 30000, 1'b1);
    nrst = 1'b0;
    #2;
    checkOutput("t5_frame_valid", frame_valid, 0);
    checkOutput("t5_slice_ready", slice_ready, 0);
    checkOutput("t5_err_short", err_short, 0);
    checkOutput("t5_err_long", err_long, 0);
    checkOutput("t5_rd_data", rd_data, 0);
    repeat (2) @(posedge clk_33);
    @(negedge clk_33);
    nrst = 1'b1;
    sendWords(WPS - 200, 30200, 1'b0);
    sendBlank(72);
    checkOutput("t5_pending", ev_q.size(), 0);
    checkOutput("t5_still_invalid", frame_valid, 0);
    sendSlice(WPS, 40000, 1'b1);
    checkOutput("t5_frame_valid_again", frame_valid, 1);
    readAll("t5_read");

    $display("[TB] read held across swap");
    @(posedge clk_33);
    #1;
    rd_addr = AW'(5);
    sendWords(WPS, 50000, 1'b1);
    ev_q.push_back(EV_READY);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      applyStimulus('0, 1'b1);
      @(negedge clk_33);
      if (slice_ready) begin
        seen = 1'b1;
        checkOutput("t6_swap_old", rd_data, golden[5]);
        @(negedge clk_33);
        checkOutput("t6_swap_new", rd_data, DW'(50005));
      end
    end
    checkOutput("t6_swap_seen", {31'd0, seen}, 1);
    sendBlank(70);
    for (int i = 0; i < WPS; i++) golden[i] = DW'(50000 + i);
    checkOutput("t6_pending", ev_q.size(), 0);
    readAll("t6_read");

    $display("[TB] error bursts");
    for (int j = 0; j < 3; j++) sendSlice(100 + j, 60000 + 1000 * j, 1'b1);
    for (int j = 0; j < 2; j++) sendSlice(520, 70000 + 1000 * j, 1'b1);
    readSpot("t7_read_unchanged");
`ifdef FB_RX_ERR_CNT_EN
    checkOutput("t7_short_cnt", short_cnt, 3);
    checkOutput("t7_long_cnt", long_cnt, 2);
`endif

    checkOutput("final_events", ev_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
